// File: rtl/ps2_key_command_decoder.sv
// ---------------------------------------------------------------------------
// ps2_key_command_decoder
//
// Turns the PS/2 receiver's rolling scan-code history (Set 2) into one-clock
// Tetris control pulses, tracks which game keys are held, and generates
// delayed auto-repeat (DAS) pulses for left, right and soft drop.
//
// Ports
//   clock         system clock
//   reset         synchronous, active-high reset
//   keycode_in    32-bit scan-code history, asynchronous to clock
//                 ([7:0] newest, [15:8] previous, [23:16] the one before)
//   move_left     one-cycle pulse (press and auto-repeat)
//   move_right    one-cycle pulse (press and auto-repeat)
//   rotate        one-cycle pulse (press only)
//   soft_drop     one-cycle pulse (press and auto-repeat)
//   hard_drop     one-cycle pulse (press only)
//   pause_toggle  one-cycle pulse (press only)
//   key_held      held flags {pause, hard, rot, down, right, left}
// ---------------------------------------------------------------------------
module ps2_key_command_decoder #(
  parameter int unsigned DAS_DELAY = 20_000_000,
  parameter int unsigned DAS_RATE  = 5_000_000,
  parameter int unsigned CNT_W     = 25
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] keycode_in,
  output logic        move_left,
  output logic        move_right,
  output logic        rotate,
  output logic        soft_drop,
  output logic        hard_drop,
  output logic        pause_toggle,
  output logic [5:0]  key_held
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned KEY_N  = 6;

  localparam logic [CNT_W-1:0] DELAY_LOAD = CNT_W'(DAS_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_LOAD  = CNT_W'(DAS_RATE - 1);

  // Bit positions inside key_held and the decoded key vectors
  localparam int unsigned K_LEFT  = 0;
  localparam int unsigned K_RIGHT = 1;
  localparam int unsigned K_DOWN  = 2;
  localparam int unsigned K_ROT   = 3;
  localparam int unsigned K_HARD  = 4;
  localparam int unsigned K_PAUSE = 5;

  localparam logic [7:0] CODE_E0    = 8'hE0;
  localparam logic [7:0] CODE_F0    = 8'hF0;
  localparam logic [7:0] CODE_LEFT  = 8'h6B;
  localparam logic [7:0] CODE_RIGHT = 8'h74;
  localparam logic [7:0] CODE_ROT   = 8'h75;
  localparam logic [7:0] CODE_DOWN  = 8'h72;
  localparam logic [7:0] CODE_HARD  = 8'h29;
  localparam logic [7:0] CODE_PAUSE = 8'h4D;

  typedef enum logic [1:0] {
    REP_NONE  = 2'd0,
    REP_LEFT  = 2'd1,
    REP_RIGHT = 2'd2,
    REP_DOWN  = 2'd3
  } rep_t;

  // Capture / synchroniser state
  logic [WORD_W-1:0] s1, s2, s3;
  logic [WORD_W-1:0] last_word;
  logic              primed;
  logic [1:0]        fill;

  // Repeat engine state
  rep_t              rep_key;
  logic [CNT_W-1:0]  cnt;

  // Combinational decode results
  logic              stable_c;
  logic              ready_c;
  logic              accept_c;
  logic [7:0]        code_b_c, code_p_c, code_pp_c;
  logic              prefix_c;
  logic              brk_c;
  logic              ext_c;
  logic [KEY_N-1:0]  key_sel_c;
  logic [KEY_N-1:0]  make_sel_c;
  logic [KEY_N-1:0]  brk_sel_c;
  logic [KEY_N-1:0]  held_next_c;
  logic              rep_broken_c;
  rep_t              rep_next_c;
  logic [CNT_W-1:0]  cnt_next_c;
  logic [2:0]        rep_pulse_c;   // {down, right, left}

  // Stability, accept and byte/key decode of the settled history word
  always_comb begin
    stable_c  = (s2 == s3);
    // s3 only holds a real post-reset sample once three edges have passed
    ready_c   = (fill == 2'd3);
    accept_c  = stable_c && primed && (s3 != last_word);

    code_b_c  = s3[7:0];
    code_p_c  = s3[15:8];
    code_pp_c = s3[23:16];

    prefix_c  = (code_b_c == CODE_E0) || (code_b_c == CODE_F0);
    brk_c     = (code_p_c == CODE_F0);
    ext_c     = (code_p_c == CODE_E0) ||
                ((code_p_c == CODE_F0) && (code_pp_c == CODE_E0));

    key_sel_c = '0;
    case (code_b_c)
      CODE_LEFT:  key_sel_c[K_LEFT]  = ext_c;
      CODE_RIGHT: key_sel_c[K_RIGHT] = ext_c;
      CODE_ROT:   key_sel_c[K_ROT]   = ext_c;
      CODE_DOWN:  key_sel_c[K_DOWN]  = ext_c;
      CODE_HARD:  key_sel_c[K_HARD]  = !ext_c;
      CODE_PAUSE: key_sel_c[K_PAUSE] = !ext_c;
      default:    key_sel_c          = '0;
    endcase

    make_sel_c = '0;
    brk_sel_c  = '0;
    if (accept_c && !prefix_c) begin
      if (brk_c) begin
        brk_sel_c = key_sel_c;
      end else begin
        // Typematic re-makes of an already-held key are dropped here
        make_sel_c = key_sel_c & ~key_held;
      end
    end

    held_next_c = (key_held | make_sel_c) & ~brk_sel_c;
  end

  // Auto-repeat: a fresh repeatable press reloads and takes over; a break of
  // the repeating key silences it on the same edge.
  always_comb begin
    rep_next_c  = rep_key;
    cnt_next_c  = cnt;
    rep_pulse_c = '0;

    unique case (rep_key)
      REP_LEFT:  rep_broken_c = brk_sel_c[K_LEFT];
      REP_RIGHT: rep_broken_c = brk_sel_c[K_RIGHT];
      REP_DOWN:  rep_broken_c = brk_sel_c[K_DOWN];
      default:   rep_broken_c = 1'b0;
    endcase

    if (make_sel_c[K_LEFT]) begin
      rep_next_c = REP_LEFT;
      cnt_next_c = DELAY_LOAD;
    end else if (make_sel_c[K_RIGHT]) begin
      rep_next_c = REP_RIGHT;
      cnt_next_c = DELAY_LOAD;
    end else if (make_sel_c[K_DOWN]) begin
      rep_next_c = REP_DOWN;
      cnt_next_c = DELAY_LOAD;
    end else if (rep_key != REP_NONE) begin
      if (rep_broken_c) begin
        rep_next_c = REP_NONE;
      end else if (cnt == '0) begin
        cnt_next_c = RATE_LOAD;
        unique case (rep_key)
          REP_LEFT:  rep_pulse_c[0] = 1'b1;
          REP_RIGHT: rep_pulse_c[1] = 1'b1;
          REP_DOWN:  rep_pulse_c[2] = 1'b1;
          default:   rep_pulse_c    = '0;
        endcase
      end else begin
        cnt_next_c = cnt - CNT_W'(1);
      end
    end
  end

  // Registered state and outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      s1           <= '0;
      s2           <= '0;
      s3           <= '0;
      last_word    <= '0;
      primed       <= 1'b0;
      fill         <= '0;
      rep_key      <= REP_NONE;
      cnt          <= '0;
      key_held     <= '0;
      move_left    <= 1'b0;
      move_right   <= 1'b0;
      rotate       <= 1'b0;
      soft_drop    <= 1'b0;
      hard_drop    <= 1'b0;
      pause_toggle <= 1'b0;
    end else begin
      s1 <= keycode_in;
      s2 <= s1;
      s3 <= s2;

      if (fill != 2'd3) begin
        fill <= fill + 2'd1;
      end

      // First settled word after reset is adopted silently
      if (!primed) begin
        if (stable_c && ready_c) begin
          last_word <= s3;
          primed    <= 1'b1;
        end
      end else if (accept_c) begin
        last_word <= s3;
      end

      key_held     <= held_next_c;
      rep_key      <= rep_next_c;
      cnt          <= cnt_next_c;

      move_left    <= make_sel_c[K_LEFT]  | rep_pulse_c[0];
      move_right   <= make_sel_c[K_RIGHT] | rep_pulse_c[1];
      soft_drop    <= make_sel_c[K_DOWN]  | rep_pulse_c[2];
      rotate       <= make_sel_c[K_ROT];
      hard_drop    <= make_sel_c[K_HARD];
      pause_toggle <= make_sel_c[K_PAUSE];
    end
  end

endmodule

// File: tb/tb_ps2_key_command_decoder.sv
// ---------------------------------------------------------------------------
// tb_ps2_key_command_decoder
//
// Directed bench for ps2_key_command_decoder with a short DAS (delay 8,
// rate 3). Each step drives a history word and checks the pulse vector
// {pause, hard, rot, down, right, left} on every following clock against a
// hand-computed list of pulse cycles (cycle 1 = first edge after the change).
// ---------------------------------------------------------------------------
module tb_ps2_key_command_decoder;

  localparam int unsigned DLY  = 8;
  localparam int unsigned RATE = 3;
  localparam int unsigned CW   = 4;

  localparam logic [5:0] NONE = 6'b000000;
  localparam logic [5:0] L    = 6'b000001;
  localparam logic [5:0] R    = 6'b000010;
  localparam logic [5:0] D    = 6'b000100;
  localparam logic [5:0] ROT  = 6'b001000;
  localparam logic [5:0] H    = 6'b010000;
  localparam logic [5:0] P    = 6'b100000;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] keycode_in;
  logic        move_left, move_right, rotate, soft_drop, hard_drop, pause_toggle;
  logic [5:0]  key_held;
  logic [5:0]  pulses;

  int checks = 0;
  int fails  = 0;

  ps2_key_command_decoder #(
    .DAS_DELAY(DLY),
    .DAS_RATE (RATE),
    .CNT_W    (CW)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .keycode_in  (keycode_in),
    .move_left   (move_left),
    .move_right  (move_right),
    .rotate      (rotate),
    .soft_drop   (soft_drop),
    .hard_drop   (hard_drop),
    .pause_toggle(pause_toggle),
    .key_held    (key_held)
  );

  always #5 clock = ~clock;

  assign pulses = {pause_toggle, hard_drop, rotate, soft_drop, move_right, move_left};

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk6(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Bitmap with a bit set at each listed cycle number (0 = unused slot)
  function automatic logic [63:0] pm(input int a, input int b = 0,
                                     input int c = 0, input int d = 0);
    logic [63:0] m;
    m = '0;
    if (a > 0) m[a] = 1'b1;
    if (b > 0) m[b] = 1'b1;
    if (c > 0) m[c] = 1'b1;
    if (d > 0) m[d] = 1'b1;
    return m;
  endfunction

  // Run n cycles checking the pulse vector each cycle
  task automatic window(input int n, input logic [63:0] ma, input logic [5:0] ba,
                        input logic [63:0] mb, input logic [5:0] bb, input string tag);
    logic [5:0] exp;
    for (int i = 1; i <= n; i++) begin
      tick();
      exp = (ma[i] ? ba : NONE) | (mb[i] ? bb : NONE);
      chk6($sformatf("%s@%0d", tag, i), pulses, exp);
    end
  endtask

  initial begin
    // 1: reset with a word already present; it must never fire
    reset      = 1'b1;
    keycode_in = 32'h0000E06B;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk6("reset_pulses", pulses, NONE);
      chk6("reset_held", key_held, 6'b000000);
    end
    reset = 1'b0;
    window(20, '0, NONE, '0, NONE, "stale");
    chk6("stale_held", key_held, 6'b000000);

    // 2: left press, 4-cycle latency, repeats at +8, +11, +14
    keycode_in = 32'h00000000;
    window(8, '0, NONE, '0, NONE, "zero_word");
    keycode_in = 32'h0000E06B;
    window(19, pm(4, 12, 15, 18), L, '0, NONE, "left_das");
    chk6("left_held", key_held, 6'b000001);

    // 3: F0 prefix (repeat keeps running), then E0 F0 6B break stops it
    keycode_in = 32'hE06BE0F0;
    window(6, pm(2, 5), L, '0, NONE, "left_prefix");
    keycode_in = 32'h6BE0F06B;
    window(20, pm(2), L, '0, NONE, "left_break");
    chk6("left_released", key_held, 6'b000000);

    // 4: hold left, then press right on the edge left's counter expires
    keycode_in = 32'h0000E06B;
    window(14, pm(4, 12), L, '0, NONE, "left_again");
    keycode_in = 32'h6BE0E074;
    window(20, pm(1), L, pm(4, 12, 15, 18), R, "right_takes_over");
    chk6("left_right_held", key_held, 6'b000011);

    // Break right on an edge where its counter is zero: no pulse, left stays quiet
    keycode_in = 32'h74E0F074;
    window(20, '0, NONE, pm(1), R, "right_break");
    chk6("right_released", key_held, 6'b000001);

    // 5: hard drop fires once, break clears it, pause fires once
    keycode_in = 32'h00000029;
    window(50, pm(4), H, '0, NONE, "hard_drop");
    chk6("hard_held", key_held, 6'b010001);
    keycode_in = 32'h0029F029;
    window(10, '0, NONE, '0, NONE, "hard_break");
    chk6("hard_released", key_held, 6'b000001);
    keycode_in = 32'h0000004D;
    window(10, pm(4), P, '0, NONE, "pause");
    chk6("pause_held", key_held, 6'b100001);

    // 6: soft drop repeating, reset on the edge a repeat is due
    keycode_in = 32'h0000E072;
    window(14, pm(4, 12), D, '0, NONE, "soft_drop");
    chk6("soft_held", key_held, 6'b100101);
    reset = 1'b1;
    tick();
    chk6("midreset_pulses", pulses, NONE);
    chk6("midreset_held", key_held, 6'b000000);
    tick();
    chk6("midreset_pulses2", pulses, NONE);
    reset = 1'b0;
    window(20, '0, NONE, '0, NONE, "reprime");
    chk6("reprime_held", key_held, 6'b000000);

    // Rotate press, then a bare prefix and an unmapped code leave state alone
    keycode_in = 32'h0000E075;
    window(10, pm(4), ROT, '0, NONE, "rotate");
    chk6("rot_held", key_held, 6'b001000);
    keycode_in = 32'h000000E0;
    window(8, '0, NONE, '0, NONE, "bare_e0");
    chk6("bare_e0_held", key_held, 6'b001000);
    keycode_in = 32'h00000055;
    window(8, '0, NONE, '0, NONE, "unmapped");
    chk6("unmapped_held", key_held, 6'b001000);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/ps2_key_command_decoder.md
Name: ps2_key_command_decoder

Overview:
- Sits directly downstream of the PS/2 receiver and consumes its 32-bit rolling scan-code history word (newest byte in [7:0]).
- Decodes Set-2 make, break and E0-extended sequences into Tetris control pulses.
- Tracks the held state of each game key and generates auto-repeat (DAS) pulses for the movement keys.
- Output pulses feed the game FSM and are one clock wide, synchronous to the system clock.

Parameters:
- DAS_DELAY, 20_000_000: cycles from the initial press pulse to the first repeat pulse (200 ms at 100 MHz); must be >= 1.
- DAS_RATE, 5_000_000: cycles between subsequent repeat pulses; must be >= 1.
- CNT_W, 25: repeat counter width; must hold max(DAS_DELAY, DAS_RATE) - 1.

Ports:
- clock  in  1  system clock; the only clock in the block.
- reset  in  1  synchronous, active-high reset.
- keycode_in  in  32  scan-code history from the receiver, asynchronous to clock; [7:0] newest, [15:8] previous, [23:16] the one before.
- move_left  out  1  one-cycle pulse.
- move_right  out  1  one-cycle pulse.
- rotate  out  1  one-cycle pulse.
- soft_drop  out  1  one-cycle pulse.
- hard_drop  out  1  one-cycle pulse.
- pause_toggle  out  1  one-cycle pulse.
- key_held  out  6  held flags {pause, hard, rot, down, right, left}, bit0 = left.

Behaviour:
Reset
- Clocking: one clock, named clock. Reset is synchronous and active-high, named reset.
- While reset is high, every output is 0, key_held = 0, the repeat engine is idle, the sync stages s1/s2/s3 are 0 and primed = 0.
- Reset asserted mid-sequence aborts everything, including pending repeats; there is no pulse on the reset cycle or the cycle after.

Capture
- keycode_in passes through the 32-bit register chain s1 -> s2 -> s3.
- The word is stable when s2 == s3.
- An accept occurs on an edge where stable, and s3 != last_word, and primed = 1. On that edge, last_word <= s3.
- If primed = 0 and the word is stable, last_word <= s3 and primed <= 1, with no decode. A stale word present at reset therefore never fires.
- Latency: input change to pulse high is 4 cycles.

Decode (on accept: B = s3[7:0], P = s3[15:8], PP = s3[23:16])
- B = E0 or B = F0: prefix byte only, no action.
- brk = (P == F0). ext = (P == E0) or (P == F0 and PP == E0).
- Key map:
  - left: ext 6B
  - right: ext 74
  - rotate: ext 75
  - soft_drop: ext 72
  - hard_drop: non-ext 29
  - pause: non-ext 4D
- Any other code is ignored, with no state change.
- A make of a key whose held bit is 0 sets the held bit and fires its pulse on the accept edge.
- A make of a key already held (typematic) does nothing.
- A break clears the held bit and never pulses.

Repeat engine
- Scope: left, right and soft_drop only. rotate, hard_drop and pause_toggle fire once per press.
- State: rep_key (none/left/right/down) and cnt[CNT_W-1:0].
- A new press of a repeatable key sets rep_key to that key and loads cnt = DAS_DELAY - 1. The last press wins; the previously held key stops repeating.
- Each cycle, if rep_key != none: when cnt == 0, pulse the rep_key output and load cnt = DAS_RATE - 1; otherwise decrement cnt.
- Result: the second pulse comes DAS_DELAY cycles after the first, then one every DAS_RATE cycles.
- A break of rep_key sets rep_key = none the same edge, with no pulse that edge. Other still-held keys do not resume repeating.
- Simultaneous events:
  - A repeat pulse and a non-repeatable press may pulse on the same cycle.
  - A repeat pulse and a new repeatable press on the same edge: the press wins (reload); only the new key pulses.

Test Plan:
1. Reset, then hold keycode_in = 0000E06B stable → no pulse. Set DAS_DELAY = 8, DAS_RATE = 3.
2. keycode_in 00000000 → 0000E06B → move_left high exactly 4 cycles after the change, then again at +8, +11, +14. key_held = 000001.
3. Same as (2), then E06BE0F0 → 6BE0F06B → repeat stops, with no pulse after the break accept. key_held = 0.
4. Hold left, then 6BE0E074 → move_right pulses at once and repeats; move_left never pulses again. key_held = 000011.
5. 00000029 → hard_drop single pulse; held for 50 cycles → no further pulse. Then 0029F029 → key_held[4] cleared. 0000004D → one pause_toggle pulse.
6. Mid-repeat reset → all outputs 0 the next cycle; after release, the unchanged word is re-primed with no pulse. Also check 000000E0 and 00000055 → no pulse, key_held unchanged.
